// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg -- shared constants and types for the program counter slice.
//
// Holds the instruction/address widths, the polarity constants for the
// control inputs, the reset instruction address and the NOP used to flush
// the instruction register. The next-address source is a small enum so the
// selection made each cycle can be observed as a named value.
//
// Optional feature macro used by this slice: PC_MISALIGN_EN (see pc.sv).
// -----------------------------------------------------------------------------
package pc_pkg;

  localparam int INST_WIDTH      = 32;
  localparam int INST_ADDR_WIDTH = 32;

  localparam logic RST   = 1'b1;
  localparam logic UNRST = 1'b0;
  localparam logic JUMP  = 1'b1;
  localparam logic HOLD  = 1'b1;

  localparam logic [INST_ADDR_WIDTH-1:0] INI_INST_ADDR = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [INST_WIDTH-1:0]      INST_NOP      = 32'h0000_0013;

  // Which source drives the next PC, in priority order.
  typedef enum logic [1:0] {
    SEL_RST  = 2'd0,
    SEL_JUMP = 2'd1,
    SEL_HOLD = 2'd2,
    SEL_INC  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel -- combinational next-address selection for the PC.
//
// Priority: rst > jump > hold > sequential +4 (wraps modulo 2^32).
// With PC_MISALIGN_EN defined, a jump target has bits [1:0] cleared;
// otherwise the target is loaded verbatim.
//
// Ports:
//   rst        in   1   reset request (RST)
//   jump       in   1   load jump_addr (JUMP)
//   hold       in   1   keep current PC (HOLD)
//   jump_addr  in   32  jump target
//   pc_cur     in   32  current PC
//   pc_next    out  32  PC value for the next edge
//   sel        out  2   source chosen (pc_sel_e), for observation
// -----------------------------------------------------------------------------
module pc_next_sel
  import pc_pkg::*;
(
  input  logic                       rst,
  input  logic                       jump,
  input  logic                       hold,
  input  logic [INST_ADDR_WIDTH-1:0] jump_addr,
  input  logic [INST_ADDR_WIDTH-1:0] pc_cur,
  output logic [INST_ADDR_WIDTH-1:0] pc_next,
  output pc_sel_e                    sel
);

  logic [INST_ADDR_WIDTH-1:0] jump_target;

`ifdef PC_MISALIGN_EN
  assign jump_target = {jump_addr[INST_ADDR_WIDTH-1:2], 2'b00};
`else
  assign jump_target = jump_addr;
`endif

  // rst is tested first so jump/hold are never looked at while resetting.
  always_comb begin
    sel = SEL_INC;
    if (rst == RST)        sel = SEL_RST;
    else if (jump == JUMP) sel = SEL_JUMP;
    else if (hold == HOLD) sel = SEL_HOLD;
  end

  always_comb begin
    pc_next = pc_cur + 32'd4;
    case (sel)
      SEL_RST:  pc_next = INI_INST_ADDR;
      SEL_JUMP: pc_next = jump_target;
      SEL_HOLD: pc_next = pc_cur;
      default:  pc_next = pc_cur + 32'd4;
    endcase
  end

endmodule

// File: rtl/pc.sv
// -----------------------------------------------------------------------------
// pc -- program counter and instruction register of the fetch stage.
//
// All outputs are registered; nothing passes combinationally from an input
// to an output. inst_o lags inst by one cycle. A jump flushes the fetched
// instruction by loading a NOP into inst_o.
//
// Build option: define PC_MISALIGN_EN to add misalign_o, which pulses for
// one cycle after a jump whose target has bits [1:0] != 0 (the loaded PC has
// those bits cleared).
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous reset, active high
//   inst        in   32  instruction fetched at pc_o
//   jump        in   1   load jump_addr into PC
//   jump_addr   in   32  jump target
//   hold        in   1   freeze PC and instruction register
//   pc_o        out  32  current instruction address
//   inst_o      out  32  instruction passed to decode
//   misalign_o  out  1   misaligned-jump pulse (PC_MISALIGN_EN only)
// -----------------------------------------------------------------------------
module pc
  import pc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_WIDTH-1:0]      inst,
  input  logic                       jump,
  input  logic [INST_ADDR_WIDTH-1:0] jump_addr,
  input  logic                       hold,
`ifdef PC_MISALIGN_EN
  output logic                       misalign_o,
`endif
  output logic [INST_ADDR_WIDTH-1:0] pc_o,
  output logic [INST_WIDTH-1:0]      inst_o
);

  logic [INST_ADDR_WIDTH-1:0] pc_next;
  pc_sel_e                    sel;

  pc_next_sel u_next_sel (
    .rst       (rst),
    .jump      (jump),
    .hold      (hold),
    .jump_addr (jump_addr),
    .pc_cur    (pc_o),
    .pc_next   (pc_next),
    .sel       (sel)
  );

  always_ff @(posedge clk) begin
    pc_o <= pc_next;
  end

  // The instruction register follows the same source selection as the PC:
  // reset and jump load a NOP, hold keeps the value, otherwise capture inst.
  always_ff @(posedge clk) begin
    case (sel)
      SEL_RST:  inst_o <= INST_NOP;
      SEL_JUMP: inst_o <= INST_NOP;
      SEL_HOLD: inst_o <= inst_o;
      default:  inst_o <= inst;
    endcase
  end

`ifdef PC_MISALIGN_EN
  // Set only on the edge that takes a misaligned jump, so it lasts one cycle.
  always_ff @(posedge clk) begin
    misalign_o <= (sel == SEL_JUMP) && (jump_addr[1:0] != 2'b00);
  end
`endif

endmodule

// File: tb/tb_pc.sv
// -----------------------------------------------------------------------------
// tb_pc -- directed testbench for pc.
// Inputs change #1 after a rising edge; outputs are checked #1 after the
// next rising edge. Build with PC_MISALIGN_EN defined to cover misalign_o.
// -----------------------------------------------------------------------------
module tb_pc;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        jump;
  logic [31:0] jump_addr;
  logic        hold;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
`ifdef PC_MISALIGN_EN
  logic        misalign_o;
`endif

  int n_checks;
  int n_pass;

  pc dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .hold       (hold),
`ifdef PC_MISALIGN_EN
    .misalign_o (misalign_o),
`endif
    .pc_o       (pc_o),
    .inst_o     (inst_o)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic j, input logic h,
                       input logic [31:0] ja, input logic [31:0] in);
    rst       = r;
    jump      = j;
    hold      = h;
    jump_addr = ja;
    inst      = in;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h55A0_8F93);
    #1;

    // Reset with unknown jump/hold must still load the reset values.
    jump = 1'bx;
    hold = 1'bx;
    step();
    check("reset_pc",   pc_o,   32'h0000_0000);
    check("reset_inst", inst_o, 32'h0000_0013);
`ifdef PC_MISALIGN_EN
    check("reset_mis", {31'd0, misalign_o}, 32'd0);
`endif

    // First edge after reset: increment and capture inst.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h55A0_8F93);
    step();
    check("inc_pc",   pc_o,   32'h0000_0004);
    check("inc_inst", inst_o, 32'h55A0_8F93);

    // Hold freezes both registers.
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    step();
    check("hold_pc",   pc_o,   32'h0000_0004);
    check("hold_inst", inst_o, 32'h55A0_8F93);

    // Jump wins over hold and flushes with a NOP.
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
    step();
    check("jmp0_pc",   pc_o,   32'h0000_0000);
    check("jmp0_inst", inst_o, 32'h0000_0013);

    drive(1'b0, 1'b1, 1'b1, 32'h0001_4294, 32'hDEAD_BEEF);
    step();
    check("jmp1_pc",   pc_o,   32'h0001_4294);
    check("jmp1_inst", inst_o, 32'h0000_0013);

    // Sequential after jump.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h1111_1111);
    step();
    check("seq_pc",   pc_o,   32'h0001_4298);
    check("seq_inst", inst_o, 32'h1111_1111);

    // Reset mid-jump.
    drive(1'b1, 1'b1, 1'b0, 32'h1234_5679, 32'h1111_1111);
    step();
    check("rstjmp_pc",   pc_o,   32'h0000_0000);
    check("rstjmp_inst", inst_o, 32'h0000_0013);
`ifdef PC_MISALIGN_EN
    check("rstjmp_mis", {31'd0, misalign_o}, 32'd0);
`endif

    // Jump to the top word, then wrap.
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1111_1111);
    step();
    check("top_pc",   pc_o,   32'hFFFF_FFFC);
    check("top_inst", inst_o, 32'h0000_0013);

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h2222_2222);
    step();
    check("wrap_pc",   pc_o,   32'h0000_0000);
    check("wrap_inst", inst_o, 32'h2222_2222);

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h3333_3333);
    step();
    check("post_wrap_pc",   pc_o,   32'h0000_0004);
    check("post_wrap_inst", inst_o, 32'h3333_3333);

    // Misaligned jump target.
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h4444_4444);
    step();
`ifdef PC_MISALIGN_EN
    check("mis_pc",  pc_o, 32'h0000_0100);
    check("mis_flag", {31'd0, misalign_o}, 32'd1);
`else
    check("mis_pc",  pc_o, 32'h0000_0102);
`endif
    check("mis_inst", inst_o, 32'h0000_0013);

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h5555_5555);
    step();
`ifdef PC_MISALIGN_EN
    check("mis_next_pc", pc_o, 32'h0000_0104);
    check("mis_clear",   {31'd0, misalign_o}, 32'd0);
`else
    check("mis_next_pc", pc_o, 32'h0000_0106);
`endif
    check("mis_next_inst", inst_o, 32'h5555_5555);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc.md
PC -- requirements
Module: pc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port rst.
REQ-002 Constant INI_INST_ADDR, default 32'h0000_0000, SHALL be the reset and initial instruction address.
REQ-003 Constant INST_NOP, default 32'h0000_0013 (addi x0,x0,0), SHALL be the instruction output value after reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous reset, active high (RST=1, UNRST=0).
REQ-006 inst  input  32  instruction word fetched at the current pc_o.
REQ-007 jump  input  1  load jump_addr into PC (JUMP=1).
REQ-008 jump_addr  input  32  jump target address.
REQ-009 hold  input  1  freeze PC and instruction register (HOLD=1).
REQ-010 pc_o  output  32  registered current instruction address.
REQ-011 inst_o  output  32  registered instruction passed to decode.
REQ-012 misalign_o  output  1  present only with PC_MISALIGN_EN (REQ-027).

Function
REQ-013 All state SHALL update only on the rising edge of clk; there SHALL be no combinational input-to-output path.
REQ-014 Next PC priority SHALL be: rst > jump > hold > sequential increment.
REQ-015 With rst=1, the next pc_o SHALL be INI_INST_ADDR and the next inst_o SHALL be INST_NOP, regardless of the other inputs.
REQ-016 With rst=0 and jump=1, the next pc_o SHALL be jump_addr, even when hold=1.
REQ-017 With rst=0, jump=0 and hold=1, pc_o and inst_o SHALL keep their values.
REQ-018 With rst=0, jump=0 and hold=0, the next pc_o SHALL be pc_o+4, modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 with no flag.
REQ-019 inst_o SHALL capture inst on every edge where rst=0 and hold=0, so it lags inst by one cycle.
REQ-020 On a jump edge, inst_o SHALL capture INST_NOP instead of inst, flushing the wrong-path fetch.
REQ-021 Latency SHALL be one cycle from any input change to its effect on pc_o and inst_o.
REQ-022 X on jump or hold while rst=1 SHALL NOT affect outputs.

Reset
REQ-023 Reset SHALL be synchronous only; asserting rst mid-sequence (during hold or jump) SHALL take effect at the next edge.
REQ-024 Reset values SHALL be: pc_o=INI_INST_ADDR, inst_o=INST_NOP, misalign_o=0.
REQ-025 The first edge after rst deasserts SHALL apply normal priority; with jump=0 and hold=0, pc_o becomes INI_INST_ADDR+4.

Configuration
REQ-026 Macro PC_MISALIGN_EN SHALL compile the alignment-check feature in or out.
REQ-027 With PC_MISALIGN_EN defined:
- misalign_o SHALL pulse high for one cycle after a jump edge whose jump_addr[1:0] is not 2'b00.
- The loaded pc_o SHALL have bits [1:0] forced to 0.
REQ-028 Without PC_MISALIGN_EN, port misalign_o SHALL be absent and jump_addr SHALL be loaded verbatim.

Structure
REQ-029 The shared defines file SHALL hold: INST_WIDTH and INST_ADDR_WIDTH (31:0), RST/UNRST, JUMP, HOLD, INI_INST_ADDR and INST_NOP.
REQ-030 The next-address selection (priority mux plus +4 adder) SHALL be one combinational sub-module pc_next_sel.
REQ-031 The registers for pc_o, inst_o and misalign_o SHALL reside in pc.

Verification
REQ-032 Reset: rst=1, inst=32'h55A0_8F93, one edge -> pc_o=0, inst_o=32'h0000_0013.
REQ-033 Increment: rst=0, jump=0, hold=0, one edge -> pc_o=4, inst_o=32'h55A0_8F93.
REQ-034 Hold: hold=1, one edge -> pc_o=4, inst_o unchanged.
REQ-035 Jump over hold: hold=1, jump=1, jump_addr=0, one edge -> pc_o=0, inst_o=NOP; then jump_addr=32'h0001_4294, one edge -> pc_o=32'h0001_4294.
REQ-036 Reset mid-jump, then wrap:
- rst=1 with jump=1 -> pc_o=0.
- Jump to 32'hFFFF_FFFC, then increment -> pc_o=0.
REQ-037 PC_MISALIGN_EN build: jump_addr=32'h0000_0102 -> pc_o=32'h0000_0100 and misalign_o=1 for exactly one cycle.
